// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader: FSM state encoding,
// frame geometry and state-class helpers.
package instruction_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_BYTE,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    function automatic logic is_accepting(loader_state_t s);
        return s inside {ST_LEN_HI, ST_LEN_LO, ST_BYTE};
    endfunction

    function automatic logic is_busy(loader_state_t s);
        return s inside {ST_LEN_HI, ST_LEN_LO, ST_BYTE, ST_WRITE};
    endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream, instruction-memory write and core-control signals of the loader.
interface instruction_loader_if
    import instruction_loader_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic                     start;
    logic                     byte_valid;
    logic [7:0]               byte_data;
    logic                     byte_ready;
    logic                     imem_we;
    logic [ADDR_W-1:0]        imem_addr;
    logic [31:0]              imem_wdata;
    logic                     core_freeze;
    logic                     core_reset;
    logic                     busy;
    logic                     error;
    logic [8*LEN_BYTES-1:0]   words_loaded;

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata,
               core_freeze, core_reset, busy, error, words_loaded
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata,
               core_freeze, core_reset, busy, error, words_loaded
    );
endinterface

// File: rtl/instruction_loader_timeout.sv
// Inter-byte idle watchdog: down-counter reloaded on clear, expires at terminal count.
module instruction_loader_timeout #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int              CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_remaining;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_remaining <= LOAD;
        end else if (i_clear) begin
            r_remaining <= LOAD;
        end else if (i_enable && (r_remaining != '0)) begin
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    assign o_expired = i_enable && (r_remaining == '0);
endmodule

// File: rtl/instruction_loader.sv
// Loads a length-prefixed big-endian word stream into instruction memory,
// freezing the core while loading and pulsing core_reset on success.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    instruction_loader_if.slave  bus
);
    localparam int                 COUNT_W  = 8 * LEN_BYTES;
    localparam int                 IDX_W    = $clog2(WORD_BYTES);
    localparam logic [COUNT_W-1:0] DEPTH_W  = COUNT_W'(DEPTH);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WORD_BYTES - 1);

    loader_state_t      r_state;
    loader_state_t      w_state_nxt;
    logic [IDX_W-1:0]   r_byte_idx;
    logic [31:0]        r_word;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_words_loaded;
    logic               r_byte_ready;
    logic               r_imem_we;
    logic               r_core_freeze;
    logic               r_core_reset;
    logic               r_busy;
    logic               r_error;

    logic               w_accept;
    logic               w_start_ok;
    logic               w_expired;
    logic [COUNT_W-1:0] w_len;
    logic [COUNT_W-1:0] w_words_inc;

    assign w_accept    = bus.byte_valid && r_byte_ready;
    assign w_start_ok  = bus.start && (r_state inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign w_len       = {r_count[COUNT_W-1:8], bus.byte_data};
    assign w_words_inc = r_words_loaded + COUNT_W'(1);

    instruction_loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_accept || w_start_ok),
        .i_enable  (is_accepting(r_state)),
        .o_expired (w_expired)
    );

    // A byte arriving on the same cycle the watchdog expires still wins.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (bus.start) w_state_nxt = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (w_accept)       w_state_nxt = ST_LEN_LO;
                else if (w_expired) w_state_nxt = ST_ERROR;
            end
            ST_LEN_LO: begin
                if (w_accept) begin
                    if (w_len == '0)          w_state_nxt = ST_DONE;
                    else if (w_len > DEPTH_W) w_state_nxt = ST_ERROR;
                    else                      w_state_nxt = ST_BYTE;
                end else if (w_expired) begin
                    w_state_nxt = ST_ERROR;
                end
            end
            ST_BYTE: begin
                if (w_accept) begin
                    if (r_byte_idx == LAST_IDX) w_state_nxt = ST_WRITE;
                end else if (w_expired) begin
                    w_state_nxt = ST_ERROR;
                end
            end
            ST_WRITE: begin
                w_state_nxt = (w_words_inc == r_count) ? ST_DONE : ST_BYTE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_byte_idx     <= '0;
            r_word         <= '0;
            r_count        <= '0;
            r_words_loaded <= '0;
            r_byte_ready   <= 1'b0;
            r_imem_we      <= 1'b0;
            r_core_freeze  <= 1'b0;
            r_core_reset   <= 1'b0;
            r_busy         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_byte_ready  <= is_accepting(w_state_nxt);
            r_busy        <= is_busy(w_state_nxt);
            r_core_freeze <= is_busy(w_state_nxt) || (w_state_nxt == ST_ERROR);
            r_error       <= (w_state_nxt == ST_ERROR);
            r_imem_we     <= (w_state_nxt == ST_WRITE);
            r_core_reset  <= (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

            if (w_start_ok) begin
                r_words_loaded <= '0;
                r_byte_idx     <= '0;
            end

            if (w_accept) begin
                if (r_state == ST_LEN_HI) begin
                    r_count[COUNT_W-1:8] <= bus.byte_data;
                end else if (r_state == ST_LEN_LO) begin
                    r_count[7:0] <= bus.byte_data;
                end else if (r_state == ST_BYTE) begin
                    r_word     <= {r_word[23:0], bus.byte_data};
                    r_byte_idx <= r_byte_idx + IDX_W'(1);
                end
            end

            if (r_state == ST_WRITE) begin
                r_words_loaded <= w_words_inc;
            end
        end
    end

    assign bus.byte_ready   = r_byte_ready;
    assign bus.imem_we      = r_imem_we;
    assign bus.imem_addr    = r_words_loaded[ADDR_W-1:0];
    assign bus.imem_wdata   = r_word;
    assign bus.core_freeze  = r_core_freeze;
    assign bus.core_reset   = r_core_reset;
    assign bus.busy         = r_busy;
    assign bus.error        = r_error;
    assign bus.words_loaded = r_words_loaded;
endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: random frames checked against a
// word-list model of what instruction memory must receive.
`timescale 1ns/1ps
module tb_instruction_loader;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int TMO    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    instruction_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_loader #(
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Observed memory writes as {addr, data}, and core_reset pulse count.
    logic [39:0] wr_q[$];
    int          cr_cnt = 0;

    always @(negedge clk) begin
        if (bus.imem_we) wr_q.push_back({bus.imem_addr, bus.imem_wdata});
        if (bus.core_reset) cr_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic build_frame(input logic [15:0] n, input logic [31:0] w[$],
                               output logic [7:0] q[$]);
        q = {};
        q.push_back(n[15:8]);
        q.push_back(n[7:0]);
        foreach (w[i])
            for (int b = 3; b >= 0; b--) q.push_back(w[i][8*b +: 8]);
    endtask

    task automatic send_bytes(input logic [7:0] q[$], input int max_gap);
        foreach (q[i]) begin
            int gap;
            int waited;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            if (gap > 0) begin
                bus.byte_valid = 1'b0;
                repeat (gap) tick();
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = q[i];
            waited = 0;
            while (!bus.byte_ready && waited < 50) begin
                tick();
                waited++;
            end
            if (!bus.byte_ready) begin
                total++;
                bad++;
                $display("FAIL send_handshake byte %0d: byte_ready=%0b, required 1", i, bus.byte_ready);
                bus.byte_valid = 1'b0;
                return;
            end
            tick();
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [61:0] outs;
        rst = 1'b1;
        tick();
        tick();
        outs = {bus.byte_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.core_freeze,
                bus.core_reset, bus.busy, bus.error, bus.words_loaded};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_two_words();
        logic [7:0] q1[$];
        logic [7:0] q2[$];
        logic [39:0] exp[2];
        q1 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
        q2 = '{8'hAC, 8'h08, 8'h00, 8'h00};
        exp[0] = {8'h00, 32'h2008_0005};
        exp[1] = {8'h01, 32'hAC08_0000};
        wr_q.delete();
        cr_cnt = 0;
        do_start();
        total++;
        if ({bus.core_freeze, bus.busy, bus.byte_ready} !== 3'b111) begin
            bad++;
            $display("FAIL two_start_flags: freeze/busy/ready=%b, required 111",
                     {bus.core_freeze, bus.busy, bus.byte_ready});
        end
        send_bytes(q1, 0);
        total++;
        if ({bus.imem_we, bus.byte_ready, bus.imem_addr, bus.imem_wdata} !== {2'b10, exp[0]}) begin
            bad++;
            $display("FAIL two_write_latency: we=%b ready=%b addr=%h data=%h, required we=1 ready=0 %h",
                     bus.imem_we, bus.byte_ready, bus.imem_addr, bus.imem_wdata, exp[0]);
        end
        send_bytes(q2, 0);
        tick();
        total++;
        if ({bus.core_reset, bus.core_freeze, bus.busy} !== 3'b100) begin
            bad++;
            $display("FAIL two_done_entry: core_reset/freeze/busy=%b, required 100",
                     {bus.core_reset, bus.core_freeze, bus.busy});
        end
        tick();
        total++;
        if (bus.core_reset !== 1'b0) begin
            bad++;
            $display("FAIL two_reset_pulse_width: core_reset=%b, required 0", bus.core_reset);
        end
        total++;
        if (wr_q.size() != 2) begin
            bad++;
            $display("FAIL two_write_count: got %0d, required 2", wr_q.size());
        end
        for (int i = 0; i < 2 && i < wr_q.size(); i++) begin
            total++;
            if (wr_q[i] !== exp[i]) begin
                bad++;
                $display("FAIL two_write_%0d: got %h, required %h", i, wr_q[i], exp[i]);
            end
        end
        total++;
        if ({cr_cnt, bus.words_loaded, bus.error} !== {32'd1, 16'd2, 1'b0}) begin
            bad++;
            $display("FAIL two_final: cr_cnt=%0d words=%0d error=%b, required 1 2 0",
                     cr_cnt, bus.words_loaded, bus.error);
        end
        // Bytes after the frame must not be consumed.
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h55;
        repeat (4) tick();
        total++;
        if (bus.byte_ready !== 1'b0 || wr_q.size() != 2 || bus.words_loaded !== 16'd2) begin
            bad++;
            $display("FAIL two_extra_bytes: ready=%b writes=%0d words=%0d, required 0 2 2",
                     bus.byte_ready, wr_q.size(), bus.words_loaded);
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic test_zero_len();
        logic [7:0] q[$];
        q = '{8'h00, 8'h00};
        wr_q.delete();
        cr_cnt = 0;
        do_start();
        send_bytes(q, 0);
        repeat (3) tick();
        total++;
        if (wr_q.size() != 0 || cr_cnt != 1 || bus.error !== 1'b0 || bus.core_freeze !== 1'b0
            || bus.words_loaded !== 16'd0) begin
            bad++;
            $display("FAIL zero_len: writes=%0d cr=%0d err=%b frz=%b words=%0d, required 0 1 0 0 0",
                     wr_q.size(), cr_cnt, bus.error, bus.core_freeze, bus.words_loaded);
        end
    endtask

    task automatic test_oversize();
        logic [15:0] lens[2];
        logic [7:0]  q[$];
        logic [31:0] w[$];
        int          n;
        lens[0] = 16'd257;
        lens[1] = 16'($urandom_range(65535, 257));
        for (int k = 0; k < 2; k++) begin
            wr_q.delete();
            cr_cnt = 0;
            do_start();
            total++;
            if (bus.error !== 1'b0) begin
                bad++;
                $display("FAIL oversize_start_clears_error[%0d]: error=%b, required 0", k, bus.error);
            end
            q = '{lens[k][15:8], lens[k][7:0]};
            send_bytes(q, 0);
            repeat (2) tick();
            total++;
            if ({bus.error, bus.core_freeze, bus.byte_ready, bus.busy} !== 4'b1100
                || wr_q.size() != 0 || cr_cnt != 0) begin
                bad++;
                $display("FAIL oversize[%0d] N=%0d: err/frz/rdy/busy=%b writes=%0d cr=%0d, required 1100 0 0",
                         k, lens[k], {bus.error, bus.core_freeze, bus.byte_ready, bus.busy},
                         wr_q.size(), cr_cnt);
            end
        end
        // Recover with a small random frame.
        n = $urandom_range(8, 1);
        w = {};
        for (int i = 0; i < n; i++) w.push_back($urandom);
        build_frame(16'(n), w, q);
        wr_q.delete();
        cr_cnt = 0;
        do_start();
        total++;
        if (bus.error !== 1'b0) begin
            bad++;
            $display("FAIL recover_error_clear: error=%b, required 0", bus.error);
        end
        send_bytes(q, 3);
        repeat (3) tick();
        total++;
        if (wr_q.size() != n || cr_cnt != 1) begin
            bad++;
            $display("FAIL recover_counts: writes=%0d cr=%0d, required %0d 1", wr_q.size(), cr_cnt, n);
        end
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            total++;
            if (wr_q[i] !== {8'(i), w[i]}) begin
                bad++;
                $display("FAIL recover_write_%0d: got %h, required %h", i, wr_q[i], {8'(i), w[i]});
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] q[$];
        int         k;
        q = '{8'h00, 8'h01, 8'($urandom), 8'($urandom)};
        wr_q.delete();
        cr_cnt = 0;
        do_start();
        send_bytes(q, 0);
        k = 0;
        while (bus.error !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        total++;
        if (k != TMO) begin
            bad++;
            $display("FAIL timeout_byte_latency: error after %0d cycles, required %0d", k, TMO);
        end
        total++;
        if (wr_q.size() != 0 || bus.core_freeze !== 1'b1 || bus.byte_ready !== 1'b0 || cr_cnt != 0) begin
            bad++;
            $display("FAIL timeout_state: writes=%0d frz=%b rdy=%b cr=%0d, required 0 1 0 0",
                     wr_q.size(), bus.core_freeze, bus.byte_ready, cr_cnt);
        end
        // Idle in the length phase right after start.
        do_start();
        k = 0;
        while (bus.error !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        total++;
        if (k != TMO) begin
            bad++;
            $display("FAIL timeout_len_latency: error after %0d cycles, required %0d", k, TMO);
        end
    endtask

    task automatic test_full_depth();
        logic [31:0] w[$];
        logic [7:0]  q[$];
        w = {};
        for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
        build_frame(16'(DEPTH), w, q);
        wr_q.delete();
        cr_cnt = 0;
        do_start();
        send_bytes(q, 5);
        repeat (3) tick();
        total++;
        if (wr_q.size() != DEPTH || cr_cnt != 1 || bus.words_loaded !== 16'(DEPTH) || bus.error !== 1'b0) begin
            bad++;
            $display("FAIL full_counts: writes=%0d cr=%0d words=%0d err=%b, required %0d 1 %0d 0",
                     wr_q.size(), cr_cnt, bus.words_loaded, bus.error, DEPTH, DEPTH);
        end
        for (int i = 0; i < DEPTH && i < wr_q.size(); i++) begin
            total++;
            if (wr_q[i] !== {8'(i), w[i]}) begin
                bad++;
                $display("FAIL full_write_%0d: got %h, required %h", i, wr_q[i], {8'(i), w[i]});
            end
        end
        if (wr_q.size() == DEPTH) begin
            total++;
            if (wr_q[DEPTH-1][39:32] !== 8'hFF) begin
                bad++;
                $display("FAIL full_last_addr: got %h, required ff", wr_q[DEPTH-1][39:32]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] w[$];
        logic [7:0]  q[$];
        logic [7:0]  part[$];
        logic [61:0] outs;
        w = {};
        for (int i = 0; i < 5; i++) w.push_back($urandom);
        build_frame(16'd5, w, q);
        wr_q.delete();
        cr_cnt = 0;
        do_start();
        part = q[0:11];
        send_bytes(part, 2);
        rst = 1'b1;
        #1;
        outs = {bus.byte_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.core_freeze,
                bus.core_reset, bus.busy, bus.error, bus.words_loaded};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL midreset_async: got %h, required 0", outs);
        end
        tick();
        total++;
        if (bus.core_freeze !== 1'b0 || cr_cnt != 0 || wr_q.size() != 2) begin
            bad++;
            $display("FAIL midreset_after: frz=%b cr=%0d writes=%0d, required 0 0 2",
                     bus.core_freeze, cr_cnt, wr_q.size());
        end
        rst = 1'b0;
        tick();
        // Reload; a start pulse mid-frame must be ignored.
        wr_q.delete();
        cr_cnt = 0;
        do_start();
        part = q[0:9];
        send_bytes(part, 2);
        do_start();
        total++;
        if (bus.busy !== 1'b1 || bus.words_loaded !== 16'd2) begin
            bad++;
            $display("FAIL midstart_ignored: busy=%b words=%0d, required 1 2", bus.busy, bus.words_loaded);
        end
        part = q[10:$];
        send_bytes(part, 2);
        repeat (3) tick();
        total++;
        if (wr_q.size() != 5 || cr_cnt != 1 || bus.words_loaded !== 16'd5) begin
            bad++;
            $display("FAIL reload_counts: writes=%0d cr=%0d words=%0d, required 5 1 5",
                     wr_q.size(), cr_cnt, bus.words_loaded);
        end
        for (int i = 0; i < 5 && i < wr_q.size(); i++) begin
            total++;
            if (wr_q[i] !== {8'(i), w[i]}) begin
                bad++;
                $display("FAIL reload_write_%0d: got %h, required %h", i, wr_q[i], {8'(i), w[i]});
            end
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        test_reset();
        test_two_words();
        test_zero_len();
        test_oversize();
        test_timeout();
        test_full_depth();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
